// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares a 16-bit SRAM between IF and MEM, moving each 32-bit word
// as two wait-stated halfword beats with alternating priority on ties.
module sram_port_arbiter #(
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_W      = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ready,
    output logic              if_freeze,
    input  logic              mem_rd_en,
    input  logic              mem_wr_en,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_ready,
    output logic              mem_freeze,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [15:0]       sram_dq_out,
    output logic              sram_dq_oe,
    input  logic [15:0]       sram_dq_in,
    output logic              sram_we_n
);
    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;
    localparam int CW = $clog2(WAIT_CYCLES + 2);

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q;
    logic              gnt_mem_q, wr_q, last_mem_q;
    logic [ADDR_W-2:0] addr_q;
    logic [31:0]       wdata_q, if_rdata_q, mem_rdata_q;
    logic [15:0]       lo_q;
    logic              if_pend, mem_pend, gnt_mem, beat_end, busy;
    logic              unused;

    assign if_pend  = if_req;
    assign mem_pend = mem_rd_en | mem_wr_en;
    // on a tie the requester that did not win last time gets the SRAM
    assign gnt_mem  = mem_pend & (~if_pend | ~last_mem_q);
    assign beat_end = cnt_q == CW'(WAIT_CYCLES);
    assign unused   = ^{if_addr[31:ADDR_W+1], if_addr[1:0], mem_addr[31:ADDR_W+1], mem_addr[1:0]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            gnt_mem_q   <= 1'b0;
            wr_q        <= 1'b0;
            last_mem_q  <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            lo_q        <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= (state_d != state_q) ? '0 : cnt_q + 1'b1;
            if (state_q == IDLE && (if_pend | mem_pend)) begin
                gnt_mem_q  <= gnt_mem;
                last_mem_q <= gnt_mem;
                wr_q       <= gnt_mem & mem_wr_en;
                addr_q     <= gnt_mem ? mem_addr[ADDR_W:2] : if_addr[ADDR_W:2];
                wdata_q    <= mem_wdata;
            end
            if (state_q == LOW && beat_end && !wr_q)
                lo_q <= sram_dq_in;
            if (state_q == HIGH && beat_end && !wr_q && gnt_mem_q)
                mem_rdata_q <= {sram_dq_in, lo_q};
            if (state_q == HIGH && beat_end && !wr_q && !gnt_mem_q)
                if_rdata_q <= {sram_dq_in, lo_q};
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = (if_pend | mem_pend) ? LOW : IDLE;
            LOW:     state_d = beat_end ? HIGH : LOW;
            HIGH:    state_d = beat_end ? DONE : HIGH;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy        = state_q == LOW || state_q == HIGH;
        sram_dq_oe  = busy & wr_q;
        sram_we_n   = ~(busy & wr_q);
        sram_addr   = {addr_q, state_q == HIGH};
        sram_dq_out = sram_dq_oe ? (state_q == HIGH ? wdata_q[31:16] : wdata_q[15:0]) : 16'h0;
        if_ready    = state_q == DONE && !gnt_mem_q;
        mem_ready   = state_q == DONE && gnt_mem_q;
        if_rdata    = if_rdata_q;
        mem_rdata   = mem_rdata_q;
        if_freeze   = if_req & ~if_ready;
        mem_freeze  = mem_pend & ~mem_ready;
    end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed tests with a ready-driven scoreboard and behavioural SRAMs.
module tb_sram_port_arbiter;
    logic        clk = 0, rst = 0;
    logic        if_req = 0, mem_rd_en = 0, mem_wr_en = 0;
    logic [31:0] if_addr = 0, mem_addr = 0, mem_wdata = 0;
    logic [31:0] if_rdata, mem_rdata;
    logic        if_ready, if_freeze, mem_ready, mem_freeze;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out, sram_dq_in;
    logic        sram_dq_oe, sram_we_n;

    logic        b_if_req = 0;
    logic [31:0] b_if_addr = 0, b_if_rdata, b_mem_rdata;
    logic        b_if_ready, b_if_freeze, b_mem_ready, b_mem_freeze;
    logic [17:0] b_sram_addr;
    logic [15:0] b_sram_dq_out, b_sram_dq_in;
    logic        b_sram_dq_oe, b_sram_we_n;

    logic [15:0] mem0 [0:1023];
    logic [15:0] mem1 [0:1023];

    typedef struct { bit m; bit w; logic [31:0] rd; } sb_t;
    sb_t sb[$];
    int n_chk = 0, n_fail = 0;
    logic [31:0] last_mem_rd = 0;

    always #5 clk = ~clk;

    sram_port_arbiter #(.WAIT_CYCLES(1), .ADDR_W(18)) u0 (
        .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_ready(if_ready), .if_freeze(if_freeze), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .mem_freeze(mem_freeze), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
        .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n));

    sram_port_arbiter #(.WAIT_CYCLES(0), .ADDR_W(18)) u1 (
        .clk(clk), .rst(rst), .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata),
        .if_ready(b_if_ready), .if_freeze(b_if_freeze), .mem_rd_en(1'b0), .mem_wr_en(1'b0),
        .mem_addr(32'h0), .mem_wdata(32'h0), .mem_rdata(b_mem_rdata), .mem_ready(b_mem_ready),
        .mem_freeze(b_mem_freeze), .sram_addr(b_sram_addr), .sram_dq_out(b_sram_dq_out),
        .sram_dq_oe(b_sram_dq_oe), .sram_dq_in(b_sram_dq_in), .sram_we_n(b_sram_we_n));

    assign sram_dq_in   = mem0[sram_addr[9:0]];
    assign b_sram_dq_in = mem1[b_sram_addr[9:0]];

    always @(posedge clk)
        if (sram_we_n === 1'b0) mem0[sram_addr[9:0]] <= sram_dq_out;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (if_ready === 1'b1 || mem_ready === 1'b1) begin
            if (sb.size() == 0) chk("unexpected_ready", {if_ready, mem_ready}, 0);
            else begin
                sb_t e;
                e = sb.pop_front();
                chk("sb_requester", {31'h0, mem_ready}, {31'h0, e.m});
                chk("sb_single_ready", {31'h0, if_ready & mem_ready}, 0);
                if (e.m) chk("sb_mem_rdata", mem_rdata, e.rd);
                else chk("sb_if_rdata", if_rdata, e.rd);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 0;
        repeat (2) @(negedge clk);
        rst = 1;
        last_mem_rd = 0;
    endtask

    task automatic push(input bit m, input bit w, input logic [31:0] rd);
        sb_t e;
        e.m = m; e.w = w; e.rd = rd;
        sb.push_back(e);
    endtask

    // one isolated access, called right after a negedge; checks the beat trace and latency
    task automatic access(input bit m, input bit w, input bit both, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] exp_rd);
        int n;
        bit done;
        logic [17:0] base;
        base = {a[18:2], 1'b0};
        if (m && !w) last_mem_rd = exp_rd;
        push(m, w, m ? last_mem_rd : exp_rd);
        if (m) begin
            mem_addr = a; mem_wdata = d; mem_wr_en = w; mem_rd_en = !w || both;
        end else begin
            if_addr = a; if_req = 1;
        end
        n = 0; done = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
            if (n <= 4) begin
                chk("beat_addr", 32'(sram_addr), 32'(base + 18'(n > 2)));
                chk("beat_we_n", {31'h0, sram_we_n}, {31'h0, !w});
                chk("beat_oe", {31'h0, sram_dq_oe}, {31'h0, w});
                if (w) chk("beat_dq_out", 32'(sram_dq_out), 32'(n > 2 ? d[31:16] : d[15:0]));
                chk("freeze_busy", {31'h0, m ? mem_freeze : if_freeze}, 1);
            end
            done = m ? mem_ready : if_ready;
        end
        chk("latency", n, 5);
        chk("freeze_at_ready", {31'h0, m ? mem_freeze : if_freeze}, 0);
        if_req = 0; mem_rd_en = 0; mem_wr_en = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n, rc, k;
        int rdy_cyc[4];
        logic [17:0] b_exp_addr[6];
        logic [31:0] b_exp_word[3];
        mem0[4] = 16'h1111; mem0[5] = 16'hE3A0;
        mem0[16] = 16'h5678; mem0[17] = 16'h1234;
        mem1[0] = 16'h0001; mem1[1] = 16'hA000; mem1[2] = 16'h0002;
        mem1[3] = 16'hB000; mem1[4] = 16'h0003; mem1[5] = 16'hC000;

        do_reset();
        chk("rst_we_n", {31'h0, sram_we_n}, 1);
        chk("rst_oe", {31'h0, sram_dq_oe}, 0);
        chk("rst_addr", 32'(sram_addr), 0);
        chk("rst_dq_out", 32'(sram_dq_out), 0);
        chk("rst_if_ready", {31'h0, if_ready}, 0);
        chk("rst_mem_ready", {31'h0, mem_ready}, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_mem_rdata", mem_rdata, 0);

        // W=0 back-to-back fetches on the second instance
        b_exp_addr = '{0, 1, 2, 3, 4, 5};
        b_exp_word = '{32'hA0000001, 32'hB0000002, 32'hC0000003};
        b_if_addr = 0; b_if_req = 1;
        n = 0; rc = 0; k = 0;
        while (rc < 3 && n < 40) begin
            @(negedge clk);
            n++;
            if ((n % 4) == 1 || (n % 4) == 2) begin
                if (k < 6) chk("b2b_addr", 32'(b_sram_addr), 32'(b_exp_addr[k]));
                k++;
            end
            if (b_if_ready) begin
                chk("b2b_cycle", n, rc * 4 + 3);
                chk("b2b_rdata", b_if_rdata, b_exp_word[rc]);
                rc++;
                b_if_addr = rc * 4;
                b_if_req = rc < 3;
            end
        end
        chk("b2b_count", rc, 3);
        b_if_req = 0;
        @(negedge clk);

        access(0, 0, 0, 32'h8, 0, 32'hE3A01111);
        @(negedge clk);
        access(1, 1, 0, 32'h404, 32'hDEADBEEF, 0);
        chk("wr_mem_lo", 32'(mem0[10'h202]), 32'hBEEF);
        chk("wr_mem_hi", 32'(mem0[10'h203]), 32'hDEAD);
        @(negedge clk);
        access(1, 0, 0, 32'h404, 0, 32'hDEADBEEF);

        // simultaneous requests held: expect MEM, IF, MEM, IF
        do_reset();
        last_mem_rd = 32'hDEADBEEF;
        push(1, 0, 32'hDEADBEEF); push(0, 0, 32'h12345678);
        push(1, 0, 32'hDEADBEEF); push(0, 0, 32'h12345678);
        if_addr = 32'h20; if_req = 1; mem_addr = 32'h404; mem_rd_en = 1;
        n = 0; rc = 0;
        while (rc < 4 && n < 60) begin
            @(negedge clk);
            n++;
            if (n <= 10) chk("tie_if_freeze", {31'h0, if_freeze}, 1);
            if (if_ready || mem_ready) begin
                rdy_cyc[rc] = n;
                rc++;
            end
        end
        if_req = 0; mem_rd_en = 0;
        chk("tie_count", rc, 4);
        chk("tie_cyc0", rdy_cyc[0], 5);
        chk("tie_cyc1", rdy_cyc[1], 11);
        chk("tie_cyc2", rdy_cyc[2], 17);
        chk("tie_cyc3", rdy_cyc[3], 23);
        @(negedge clk);

        // reset during HIGH beat of a write, then re-serve
        mem_addr = 32'h408; mem_wdata = 32'h12345678; mem_wr_en = 1;
        repeat (3) @(negedge clk);
        chk("abort_in_high", 32'(sram_addr), 32'h205);
        rst = 0;
        @(negedge clk);
        chk("abort_we_n", {31'h0, sram_we_n}, 1);
        chk("abort_oe", {31'h0, sram_dq_oe}, 0);
        chk("abort_addr", 32'(sram_addr), 0);
        chk("abort_no_ready", {31'h0, mem_ready}, 0);
        rst = 1;
        last_mem_rd = 0;
        push(1, 1, 0);
        n = 0;
        while (!mem_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reserve_lat", n, 5);
        mem_wr_en = 0;
        chk("abort_mem_lo", 32'(mem0[10'h204]), 32'h5678);
        chk("abort_mem_hi", 32'(mem0[10'h205]), 32'h1234);
        @(negedge clk);

        access(1, 1, 1, 32'h40C, 32'hCAFEF00D, 0);
        chk("rdwr_mem_lo", 32'(mem0[10'h206]), 32'hF00D);
        chk("rdwr_mem_hi", 32'(mem0[10'h207]), 32'hCAFE);
        chk("rdwr_rdata_kept", mem_rdata, 0);

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
